// File: rtl/line_mem_responder.sv
// line_mem_responder: line-granular main memory that serves whole-line reads and writes with a fixed latency.
// Defining MEM_STATS_EN adds rd_cnt/wr_cnt completion counters.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN = 9,
  parameter int LATENCY = 50,
  localparam int LINE_SIZE = 2 ** LINE_ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [31:0]         wr_line [LINE_SIZE],
  output logic [31:0]         rd_line [LINE_SIZE],
  output logic                gnt
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
`endif
);

  localparam int LINES = 2 ** ADDR_LEN;
  localparam int CNT_W = $clog2(LATENCY + 1);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("line_mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [31:0] line_t [LINE_SIZE];
  typedef line_t mem_t [LINES];

  // Power-up image: each word holds its own word address, so untouched lines are recognisable.
  function automatic mem_t init_mem();
    mem_t m;
    for (int a = 0; a < LINES; a++) begin
      for (int k = 0; k < LINE_SIZE; k++) begin
        m[a][k] = 32'((a << LINE_ADDR_LEN) | k);
      end
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_LEN-1:0] addr_q;
  logic                op_wr_q;
  line_t               data_q;
  logic                commit;

  assign commit = (state == BUSY) && (cnt == '0);
  assign gnt    = (state == DONE);

  // The array has no reset; a reset arriving on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && op_wr_q) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      op_wr_q <= 1'b0;
      data_q  <= '{default: '0};
      rd_line <= '{default: '0};
`ifdef MEM_STATS_EN
      rd_cnt  <= '0;
      wr_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr_req || rd_req) begin
            addr_q  <= addr;
            op_wr_q <= wr_req;
            data_q  <= wr_line;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!op_wr_q) begin
              rd_line <= mem[addr_q];
            end
`ifdef MEM_STATS_EN
            if (op_wr_q) begin
              wr_cnt <= wr_cnt + 32'd1;
            end else begin
              rd_cnt <= rd_cnt + 32'd1;
            end
`endif
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
